// File: rtl/dpram_access_arbiter.sv
// dpram_access_arbiter
// Shares the single DPRAM command port among the FSM operand fetch (read),
// the accumulator writeback (write) and the external host (read/write).
// FSM and writeback alternate round-robin; the host gets exclusive access
// after in-flight reads have drained.
//
// Handshake (all three requesters): gnt is combinational from req and the
// arbiter state; a transfer happens on the rising edge where req && gnt;
// the requester holds req/addr/data stable until it sees gnt.
//
// Timing: the accepted command drives mem_* for exactly one cycle, starting
// one cycle after acceptance. mem_rdata is sampled RD_LATENCY edges after
// the edge that raised mem_en, so the matching rvalid/rdata appears
// RD_LATENCY+1 cycles after the grant.
module dpram_access_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int DP_ADDR_WIDTH = 10,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     fsm_rst,
  input  logic                     mem_ext_en,
  output logic                     ext_owns,
  input  logic                     fsm_req,
  input  logic [DP_ADDR_WIDTH-1:0] fsm_addr,
  output logic                     fsm_gnt,
  output logic                     fsm_rvalid,
  output logic [DATA_WIDTH-1:0]    fsm_rdata,
  input  logic                     wb_req,
  input  logic [DP_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_wdata,
  output logic                     wb_gnt,
  input  logic                     ext_req,
  input  logic                     ext_we,
  input  logic [DP_ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0]    ext_wdata,
  output logic                     ext_gnt,
  output logic                     ext_rvalid,
  output logic [DATA_WIDTH-1:0]    ext_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [DP_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EXT   = 2'd2
  } arb_state_t;

  arb_state_t state_q, state_d;
  logic       drain_to_ext_q, drain_to_ext_d;  // where DRAIN goes once empty
  logic       rr_wb_q, rr_wb_d;                // 1: writeback won last

  // Owner tags of reads in flight; bit 0 is the newest.
  logic [RD_LATENCY-1:0] tag_fsm_q, tag_fsm_d;
  logic [RD_LATENCY-1:0] tag_ext_q, tag_ext_d;
  logic                  pipe_empty;

  logic                     cmd_en_d, cmd_we_d;
  logic [DP_ADDR_WIDTH-1:0] cmd_addr_d;
  logic [DATA_WIDTH-1:0]    cmd_wdata_d;
  logic                     cmd_en_q, cmd_we_q;
  logic [DP_ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0]    cmd_wdata_q;

  logic                  fsm_rvalid_q, ext_rvalid_q;
  logic [DATA_WIDTH-1:0] fsm_rdata_q, ext_rdata_q;

  assign pipe_empty = (tag_fsm_q == '0) && (tag_ext_q == '0);

  // Next state, grants, command selection and tag shift.
  always_comb begin
    state_d        = state_q;
    drain_to_ext_d = drain_to_ext_q;
    rr_wb_d        = rr_wb_q;
    fsm_gnt        = 1'b0;
    wb_gnt         = 1'b0;
    ext_gnt        = 1'b0;
    cmd_en_d       = 1'b0;
    cmd_we_d       = 1'b0;
    cmd_addr_d     = '0;
    cmd_wdata_d    = '0;

    // Grants are forced low while reset is held, not just after the edge.
    if (!fsm_rst) begin
      case (state_q)
        ST_ARB: begin
          if (mem_ext_en) begin
            // Host wins the port: no grant this cycle, start draining.
            state_d        = ST_DRAIN;
            drain_to_ext_d = 1'b1;
          end else if (fsm_req && wb_req) begin
            fsm_gnt = rr_wb_q;
            wb_gnt  = !rr_wb_q;
          end else begin
            fsm_gnt = fsm_req;
            wb_gnt  = wb_req;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state_d = (drain_to_ext_q && mem_ext_en) ? ST_EXT : ST_ARB;
          end
        end
        ST_EXT: begin
          ext_gnt = ext_req;
          if (!mem_ext_en) begin
            state_d        = ST_DRAIN;
            drain_to_ext_d = 1'b0;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end

    if (fsm_gnt) begin
      rr_wb_d = 1'b0;
    end else if (wb_gnt) begin
      rr_wb_d = 1'b1;
    end

    // At most one grant is ever active, so a priority mux is sufficient.
    if (fsm_gnt) begin
      cmd_en_d   = 1'b1;
      cmd_addr_d = fsm_addr;
    end else if (wb_gnt) begin
      cmd_en_d    = 1'b1;
      cmd_we_d    = 1'b1;
      cmd_addr_d  = wb_addr;
      cmd_wdata_d = wb_wdata;
    end else if (ext_gnt) begin
      cmd_en_d    = 1'b1;
      cmd_we_d    = ext_we;
      cmd_addr_d  = ext_addr;
      cmd_wdata_d = ext_we ? ext_wdata : '0;
    end

    // Writes push an empty slot; only reads carry an owner.
    tag_fsm_d    = tag_fsm_q << 1;
    tag_fsm_d[0] = fsm_gnt;
    tag_ext_d    = tag_ext_q << 1;
    tag_ext_d[0] = ext_gnt && !ext_we;
  end

  // State, command register and tag pipeline; reset drops in-flight tags.
  always_ff @(posedge clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_q        <= ST_ARB;
      drain_to_ext_q <= 1'b0;
      rr_wb_q        <= 1'b1;
      tag_fsm_q      <= '0;
      tag_ext_q      <= '0;
      cmd_en_q       <= 1'b0;
      cmd_we_q       <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      drain_to_ext_q <= drain_to_ext_d;
      rr_wb_q        <= rr_wb_d;
      tag_fsm_q      <= tag_fsm_d;
      tag_ext_q      <= tag_ext_d;
      cmd_en_q       <= cmd_en_d;
      cmd_we_q       <= cmd_we_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_wdata_q    <= cmd_wdata_d;
    end
  end

  // Read return: capture mem_rdata for the owner of the oldest tag.
  always_ff @(posedge clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      fsm_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      fsm_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      fsm_rvalid_q <= tag_fsm_q[RD_LATENCY-1];
      ext_rvalid_q <= tag_ext_q[RD_LATENCY-1];
      if (tag_fsm_q[RD_LATENCY-1]) begin
        fsm_rdata_q <= mem_rdata;
      end
      if (tag_ext_q[RD_LATENCY-1]) begin
        ext_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en     = cmd_en_q;
  assign mem_we     = cmd_we_q;
  assign mem_addr   = cmd_addr_q;
  assign mem_wdata  = cmd_wdata_q;
  assign fsm_rvalid = fsm_rvalid_q;
  assign fsm_rdata  = fsm_rdata_q;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;
  assign ext_owns   = (state_q == ST_EXT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Testbench for dpram_access_arbiter: directed scenarios plus randomized
// FSM/writeback/host traffic against a behavioural memory/arbitration model.
module tb_dpram_access_arbiter;
  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic fsm_rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          mem_ext_en, ext_owns;
  logic          fsm_req, fsm_gnt, fsm_rvalid;
  logic [AW-1:0] fsm_addr;
  logic [DW-1:0] fsm_rdata;
  logic          wb_req, wb_gnt;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic          ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  dpram_access_arbiter #(.DATA_WIDTH(DW), .DP_ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .fsm_rst(fsm_rst), .mem_ext_en(mem_ext_en), .ext_owns(ext_owns),
    .fsm_req(fsm_req), .fsm_addr(fsm_addr), .fsm_gnt(fsm_gnt),
    .fsm_rvalid(fsm_rvalid), .fsm_rdata(fsm_rdata),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_gnt(wb_gnt),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // DPRAM stand-in: read data for the address presented with mem_en is
  // available to be sampled on the following edge; writes land on that edge.
  logic [DW-1:0] dpram [1024];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) dpram[i] <= DW'(i);
    end else if (mem_en && mem_we) begin
      dpram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = dpram[mem_addr];

  // ---------------- scoreboard ----------------
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } cmd_t;
  typedef struct { logic [DW-1:0] data; int cyc; } rd_t;
  cmd_t exp_cmd_q[$];
  rd_t  exp_fsm_q[$];
  rd_t  exp_ext_q[$];
  logic [DW-1:0] ref_mem [1024];   // memory contents in grant order
  logic last_wb;                   // last FSM/WB winner was writeback
  logic mon_en = 1'b0;
  logic arb_chk_en = 1'b0;         // bench knows the arbiter is sharing FSM/WB
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  cmd_t mc;
  rd_t  mr;
  // Monitor: compare outputs against expectations, then record new transfers.
  always @(negedge clk) begin
    if (mon_en && !fsm_rst) begin
      if (mem_en) begin
        if (exp_cmd_q.size() == 0) check("mem_en_spurious", mem_en, 1'b0);
        else begin
          mc = exp_cmd_q.pop_front();
          check("mem_cmd_latency", cyc, mc.cyc + 1);
          check("mem_we", mem_we, mc.we);
          check("mem_addr", mem_addr, mc.addr);
          if (mc.we) check("mem_wdata", mem_wdata, mc.wdata);
        end
      end else if (exp_cmd_q.size() != 0) begin
        void'(exp_cmd_q.pop_front());
        check("mem_en_missing", mem_en, 1'b1);
      end

      if (exp_fsm_q.size() != 0 && exp_fsm_q[0].cyc + LAT + 1 < cyc) begin
        mr = exp_fsm_q.pop_front();
        check("fsm_rvalid_missing", cyc, mr.cyc + LAT + 1);
      end
      if (fsm_rvalid) begin
        if (exp_fsm_q.size() == 0) check("fsm_rvalid_spurious", fsm_rvalid, 1'b0);
        else begin
          mr = exp_fsm_q.pop_front();
          check("fsm_rvalid_latency", cyc, mr.cyc + LAT + 1);
          check("fsm_rdata", fsm_rdata, mr.data);
        end
      end
      if (exp_ext_q.size() != 0 && exp_ext_q[0].cyc + LAT + 1 < cyc) begin
        mr = exp_ext_q.pop_front();
        check("ext_rvalid_missing", cyc, mr.cyc + LAT + 1);
      end
      if (ext_rvalid) begin
        if (exp_ext_q.size() == 0) check("ext_rvalid_spurious", ext_rvalid, 1'b0);
        else begin
          mr = exp_ext_q.pop_front();
          check("ext_rvalid_latency", cyc, mr.cyc + LAT + 1);
          check("ext_rdata", ext_rdata, mr.data);
        end
      end

      if (arb_chk_en) begin
        check("ext_gnt_in_arb", ext_gnt, 1'b0);
        check("grant_count", int'(fsm_gnt) + int'(wb_gnt), (fsm_req || wb_req) ? 1 : 0);
        if (fsm_req && wb_req) check("rr_winner_fsm", fsm_gnt, last_wb);
      end

      if (fsm_req && fsm_gnt) begin
        mc.we = 1'b0; mc.addr = fsm_addr; mc.wdata = '0; mc.cyc = cyc;
        exp_cmd_q.push_back(mc);
        mr.data = ref_mem[fsm_addr]; mr.cyc = cyc;
        exp_fsm_q.push_back(mr);
        last_wb = 1'b0;
      end
      if (wb_req && wb_gnt) begin
        mc.we = 1'b1; mc.addr = wb_addr; mc.wdata = wb_wdata; mc.cyc = cyc;
        exp_cmd_q.push_back(mc);
        ref_mem[wb_addr] = wb_wdata;
        last_wb = 1'b1;
      end
      if (ext_req && ext_gnt) begin
        mc.we = ext_we; mc.addr = ext_addr; mc.wdata = ext_wdata; mc.cyc = cyc;
        exp_cmd_q.push_back(mc);
        if (ext_we) ref_mem[ext_addr] = ext_wdata;
        else begin
          mr.data = ref_mem[ext_addr]; mr.cyc = cyc;
          exp_ext_q.push_back(mr);
        end
      end
    end
  end

  // ---------------- driver tasks (start and end at posedge + 1) ----------------
  task automatic wait_grant(input int who);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      case (who)
        0:       got = fsm_gnt;
        1:       got = wb_gnt;
        default: got = ext_gnt;
      endcase
    end
    check("grant_seen", got, 1'b1);
    @(posedge clk); #1;
    case (who)
      0:       fsm_req = 1'b0;
      1:       wb_req = 1'b0;
      default: ext_req = 1'b0;
    endcase
  endtask

  task automatic fsm_read(input logic [AW-1:0] a);
    fsm_req = 1'b1; fsm_addr = a;
    wait_grant(0);
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_req = 1'b1; wb_addr = a; wb_wdata = d;
    wait_grant(1);
  endtask

  task automatic ext_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    wait_grant(2);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 10'h3FF;
      default: return AW'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic clear_expectations();
    exp_cmd_q.delete();
    exp_fsm_q.delete();
    exp_ext_q.delete();
    last_wb = 1'b1;
  endtask

  // Watchdog: the run must always end.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int  n_fsm, n_wb;
  bit  fsm_done, wb_done;
  initial begin
    fsm_rst = 1'b1; preload = 1'b1; mem_ext_en = 1'b0;
    fsm_req = 1'b1; fsm_addr = '0;
    wb_req = 1'b0; wb_addr = '0; wb_wdata = '0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = DW'(i);
    last_wb = 1'b1;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;

    // Reset state, with requests asserted to prove grants are held off.
    @(negedge clk);
    check("rst_fsm_gnt", fsm_gnt, 1'b0);
    check("rst_ext_gnt", ext_gnt, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fsm_rvalid", fsm_rvalid, 1'b0);
    check("rst_ext_rvalid", ext_rvalid, 1'b0);
    check("rst_fsm_rdata", fsm_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_ext_owns", ext_owns, 1'b0);
    @(posedge clk); #1;
    fsm_req = 1'b0; ext_req = 1'b0; fsm_rst = 1'b0;
    mon_en = 1'b1; arb_chk_en = 1'b1;

    // Single FSM read of a preloaded word.
    fsm_req = 1'b1; fsm_addr = 10'h005;
    @(negedge clk); check("t1_fsm_gnt", fsm_gnt, 1'b1);
    @(posedge clk); #1 fsm_req = 1'b0;
    @(negedge clk);
    check("t1_mem_en", mem_en, 1'b1);
    check("t1_mem_addr", mem_addr, 10'h005);
    @(negedge clk);
    check("t1_fsm_rvalid", fsm_rvalid, 1'b1);
    check("t1_fsm_rdata", fsm_rdata, 8'h05);
    @(posedge clk); #1;

    // FSM and WB held together: strict alternation, one grant per cycle.
    n_fsm = 0; n_wb = 0;
    fsm_req = 1'b1; wb_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fsm_addr = rand_addr(); wb_addr = AW'($urandom_range(32, 63)); wb_wdata = DW'($urandom);
      @(negedge clk);
      n_fsm += int'(fsm_gnt); n_wb += int'(wb_gnt);
      @(posedge clk); #1;
    end
    fsm_req = 1'b0; wb_req = 1'b0;
    check("t2_fsm_grants", n_fsm, 3);
    check("t2_wb_grants", n_wb, 3);

    // Write at the top address, then read it back.
    wb_write(10'h3FF, 8'hA5);
    fsm_read(10'h3FF);
    repeat (3) @(posedge clk); #1;
    check("t3_fsm_rdata", fsm_rdata, 8'hA5);

    // Randomized FSM/WB traffic.
    fsm_done = 1'b0; wb_done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (fsm_done) fsm_req = 1'b0;
      if (wb_done) wb_req = 1'b0;
      if (!fsm_req && $urandom_range(0, 2) != 0) begin fsm_req = 1'b1; fsm_addr = rand_addr(); end
      if (!wb_req && $urandom_range(0, 2) != 0) begin
        wb_req = 1'b1; wb_addr = rand_addr(); wb_wdata = DW'($urandom);
      end
      @(negedge clk);
      fsm_done = fsm_req && fsm_gnt;
      wb_done = wb_req && wb_gnt;
      @(posedge clk); #1;
    end
    if (fsm_done) fsm_req = 1'b0;
    if (wb_done) wb_req = 1'b0;
    if (fsm_req) wait_grant(0);
    if (wb_req) wait_grant(1);
    repeat (4) @(posedge clk); #1;

    // Host request right after an FSM read: drain, then exclusive access.
    arb_chk_en = 1'b0;
    fsm_req = 1'b1; fsm_addr = 10'h020;
    @(negedge clk); check("t4_fsm_gnt", fsm_gnt, 1'b1);
    @(posedge clk); #1;
    fsm_addr = 10'h021; mem_ext_en = 1'b1;   // new FSM read left pending
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("t4_ext_owns", ext_owns, (c >= 3) ? 1 : 0);
      check("t4_no_fsm_gnt", fsm_gnt, 1'b0);
      check("t4_no_wb_gnt", wb_gnt, 1'b0);
      @(posedge clk); #1;
    end

    // Host write, random host traffic, host read-back, then release.
    ext_op(1'b1, 10'h010, 8'h3C);
    for (int n = 0; n < 8; n++) ext_op($urandom_range(0, 1) == 1, rand_addr(), DW'($urandom));
    ext_op(1'b0, 10'h010, 8'h00);
    mem_ext_en = 1'b0;
    @(negedge clk);
    check("t5_owns_still", ext_owns, 1'b1);
    check("t5_fsm_wait1", fsm_gnt, 1'b0);
    @(negedge clk);
    check("t5_owns_dropped", ext_owns, 1'b0);
    check("t5_fsm_wait2", fsm_gnt, 1'b0);
    @(negedge clk);
    check("t5_fsm_regrant", fsm_gnt, 1'b1);
    check("t5_ext_rdata", ext_rdata, 8'h3C);
    @(posedge clk); #1 fsm_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset while a read is in flight.
    arb_chk_en = 1'b1;
    fsm_req = 1'b1; fsm_addr = 10'h007;
    @(negedge clk); check("t6_fsm_gnt", fsm_gnt, 1'b1);
    @(posedge clk); #1 fsm_req = 1'b0;
    #2 fsm_rst = 1'b1;
    clear_expectations();
    fsm_req = 1'b1; wb_req = 1'b1; fsm_addr = 10'h008; wb_addr = 10'h009; wb_wdata = 8'h77;
    #1;
    check("t6_mem_en", mem_en, 1'b0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_fsm_rvalid", fsm_rvalid, 1'b0);
    check("t6_fsm_gnt_rst", fsm_gnt, 1'b0);
    check("t6_wb_gnt_rst", wb_gnt, 1'b0);
    @(posedge clk); #1 fsm_rst = 1'b0;
    @(negedge clk);
    check("t6_tie_fsm", fsm_gnt, 1'b1);
    check("t6_tie_wb", wb_gnt, 1'b0);
    @(posedge clk); #1 fsm_req = 1'b0;
    wait_grant(1);
    repeat (5) @(posedge clk); #1;

    check("end_cmd_q_empty", exp_cmd_q.size(), 0);
    check("end_fsm_q_empty", exp_fsm_q.size(), 0);
    check("end_ext_q_empty", exp_ext_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
